// File: rtl/scaler_h_ctrl_if.sv
// Bus bundle for scaler_h_ctrl: config handshake, video input from the
// source and registered video output towards scaler_h.
// master = source/config side, slave = scaler_h_ctrl.
interface scaler_h_ctrl_if #(
  parameter int PIXEL_WIDTH = 8
);
  // Config handshake: a step is transferred on a cycle where
  // cfg_valid_i && cfg_ready_o. The master holds cfg_step_i stable while
  // cfg_valid_i is high; the slave may hold off with cfg_ready_o=0.
  logic [15:0]            cfg_step_i;
  logic                   cfg_valid_i;
  logic                   cfg_ready_o;
  logic                   cfg_rej_o;

  // Source video (one pixel per cycle, hs/vs are 1-cycle pulses)
  logic [PIXEL_WIDTH-1:0] di_i;
  logic                   de_i;
  logic                   hs_i;
  logic                   vs_i;

  // Video to scaler_h, one cycle later
  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;

  modport master (
    output cfg_step_i, cfg_valid_i, di_i, de_i, hs_i, vs_i,
    input  cfg_ready_o, cfg_rej_o, do_o, de_o, hs_o, vs_o
  );

  modport slave (
    input  cfg_step_i, cfg_valid_i, di_i, de_i, hs_i, vs_i,
    output cfg_ready_o, cfg_rej_o, do_o, de_o, hs_o, vs_o
  );
endinterface

// File: rtl/scaler_h_ctrl.sv
// scaler_h_ctrl: frame-synchronous front-end for scaler_h.
// Delays video by one cycle, keeps a one-deep shadow of the requested
// scale step and makes it live only on frame start (vs_i), so the scaler
// never changes ratio inside a frame.
// Optional output monitor (width/height measurement, line-width error) is
// built only when SCALER_H_CTRL_MON_EN is defined; otherwise its outputs
// are tied to zero and its inputs are ignored.
module scaler_h_ctrl #(
  parameter int          PIXEL_WIDTH = 8,
  parameter logic [15:0] PIXEL_STEP  = 16'd128,
  parameter logic [15:0] STEP_MIN    = 16'd32,
  parameter logic [15:0] STEP_MAX    = 16'd1024
) (
  input  logic                clk,
  input  logic                rst,
  scaler_h_ctrl_if.slave      bus,
  output logic [15:0]         scale_step_o,
  output logic                pend_o,
  output logic [15:0]         frame_cnt_o,
  input  logic                sde_i,
  input  logic                shs_i,
  input  logic                svs_i,
  output logic [15:0]         out_w_o,
  output logic [15:0]         out_h_o,
  output logic                err_o,
  input  logic                err_clr_i,
  output logic                dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            shadow_q, shadow_d;
  logic [15:0]            step_q, step_d;
  logic                   rej_q, rej_d;
  logic [15:0]            frame_q, frame_d;
  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  logic                   de_q, de_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   step_ok;

  // Inclusive unsigned range check; zero is never a legal step
  assign step_ok = (bus.cfg_step_i != 16'd0) &&
                   (bus.cfg_step_i >= STEP_MIN) &&
                   (bus.cfg_step_i <= STEP_MAX);

  // Config FSM: accept into the shadow in IDLE, apply on frame start in PEND
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    step_d   = step_q;
    rej_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid_i) begin
          if (step_ok) begin
            shadow_d = bus.cfg_step_i;
            state_d  = ST_PEND;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_PEND: begin
        if (bus.vs_i) begin
          step_d  = shadow_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Video delay line and frame counter (free-running, wraps)
  always_comb begin
    do_d    = bus.di_i;
    de_d    = bus.de_i;
    hs_d    = bus.hs_i;
    vs_d    = bus.vs_i;
    frame_d = bus.vs_i ? frame_q + 16'd1 : frame_q;
  end

  // State, config and video registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= PIXEL_STEP;
      step_q   <= PIXEL_STEP;
      rej_q    <= 1'b0;
      frame_q  <= 16'd0;
      do_q     <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      step_q   <= step_d;
      rej_q    <= rej_d;
      frame_q  <= frame_d;
      do_q     <= do_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign bus.cfg_ready_o = (state_q == ST_IDLE);
  assign bus.cfg_rej_o   = rej_q;
  assign bus.do_o        = do_q;
  assign bus.de_o        = de_q;
  assign bus.hs_o        = hs_q;
  assign bus.vs_o        = vs_q;
  assign scale_step_o    = step_q;
  assign pend_o          = (state_q == ST_PEND);
  assign frame_cnt_o     = frame_q;
  assign dbg_state_o     = state_q;

`ifdef SCALER_H_CTRL_MON_EN
  logic        armed_q, armed_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] line_q, line_d;
  logic [15:0] ref_q, ref_d;
  logic        ref_vld_q, ref_vld_d;
  logic [15:0] w_q, w_d;
  logic [15:0] h_q, h_d;
  logic        err_q, err_d;
  logic        line_close;
  logic        line_nz;
  logic        line_bad;
  logic [15:0] line_inc;
  logic [15:0] ref_cur;

  // Monitor: a line closes on shs_i or svs_i; empty lines are ignored,
  // the first non-empty line of a frame becomes the reference width
  always_comb begin
    armed_d    = armed_q;
    pix_d      = pix_q;
    line_d     = line_q;
    ref_d      = ref_q;
    ref_vld_d  = ref_vld_q;
    w_d        = w_q;
    h_d        = h_q;
    err_d      = err_q;
    line_close = armed_q && (shs_i || svs_i);
    line_nz    = (pix_q != 16'd0);
    line_bad   = line_close && line_nz && ref_vld_q && (pix_q != ref_q);
    ref_cur    = ref_vld_q ? ref_q : pix_q;
    line_inc   = (line_close && line_nz && (line_q != 16'hFFFF)) ?
                 line_q + 16'd1 : line_q;
    if (!armed_q) begin
      // The first frame after reset is partial: only arm on its svs_i
      pix_d     = 16'd0;
      line_d    = 16'd0;
      ref_d     = 16'd0;
      ref_vld_d = 1'b0;
      if (svs_i) armed_d = 1'b1;
    end else if (svs_i) begin
      w_d       = ref_cur;
      h_d       = line_inc;
      pix_d     = 16'd0;
      line_d    = 16'd0;
      ref_d     = 16'd0;
      ref_vld_d = 1'b0;
    end else if (shs_i) begin
      if (line_nz && !ref_vld_q) begin
        ref_d     = pix_q;
        ref_vld_d = 1'b1;
      end
      line_d = line_inc;
      pix_d  = {15'd0, sde_i};
    end else if (sde_i && (pix_q != 16'hFFFF)) begin
      pix_d = pix_q + 16'd1;
    end
    // A new mismatch outranks a simultaneous clear
    if (line_bad)       err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  // Monitor registers
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b0;
      pix_q     <= 16'd0;
      line_q    <= 16'd0;
      ref_q     <= 16'd0;
      ref_vld_q <= 1'b0;
      w_q       <= 16'd0;
      h_q       <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      ref_q     <= ref_d;
      ref_vld_q <= ref_vld_d;
      w_q       <= w_d;
      h_q       <= h_d;
      err_q     <= err_d;
    end
  end

  assign out_w_o = w_q;
  assign out_h_o = h_q;
  assign err_o   = err_q;
`else
  logic unused_mon;
  assign unused_mon = ^{sde_i, shs_i, svs_i, err_clr_i};
  assign out_w_o    = 16'd0;
  assign out_h_o    = 16'd0;
  assign err_o      = 1'b0;
`endif

endmodule
